// File: rtl/load_store_unit_if.sv
// CPU request / memory bus / response bundle for load_store_unit.
// slave = the LSU's view, master = the view of whatever drives the LSU (CPU + memory).
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_ack, mem_rdata,
      output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output rsp_valid, rsp_rdata, rsp_err
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output mem_ack, mem_rdata,
      input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: lane steering, extension, misalignment errors.
// Define LSU_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without mem_ack.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   load_store_unit_if.slave   bus_if
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]  state_q, state_d;
   logic        req_ready_q, req_ready_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  lo_q, lo_d;

   logic        misaligned_c;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] lane_c;
   logic [31:0] load_c;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // Request decode: alignment, byte lanes and replicated store data
   always_comb begin
      misaligned_c = (bus_if.req_size == 2'b11)
                   || (bus_if.req_size == 2'b01 && bus_if.req_addr[0])
                   || (bus_if.req_size == 2'b10 && bus_if.req_addr[1:0] != 2'b00);
      be_c    = 4'b1111;
      wdata_c = bus_if.req_wdata;
      if (bus_if.req_we) begin
         case (bus_if.req_size)
            2'b00: begin
               be_c    = 4'b0001 << bus_if.req_addr[1:0];
               wdata_c = {4{bus_if.req_wdata[7:0]}};
            end
            2'b01: begin
               be_c    = bus_if.req_addr[1] ? 4'b1100 : 4'b0011;
               wdata_c = {2{bus_if.req_wdata[15:0]}};
            end
            default: ;
         endcase
      end else begin
         wdata_c = 32'd0;
      end
   end

   // Load lane extraction and extension from the latched size/offset
   always_comb begin
      lane_c = bus_if.mem_rdata >> {lo_q, 3'b000};
      case (size_q)
         2'b00:   load_c = uns_q ? {24'd0, lane_c[7:0]}   : {{24{lane_c[7]}}, lane_c[7:0]};
         2'b01:   load_c = uns_q ? {16'd0, lane_c[15:0]}  : {{16{lane_c[15]}}, lane_c[15:0]};
         default: load_c = bus_if.mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      req_ready_d = 1'b0;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = 32'd0;
      mem_be_d    = 4'd0;
      mem_wdata_d = 32'd0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'd0;
      rsp_err_d   = 1'b0;
      size_d      = size_q;
      uns_d       = uns_q;
      lo_d        = lo_q;
`ifdef LSU_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (bus_if.req_valid) begin
               req_ready_d = 1'b0;
               size_d      = bus_if.req_size;
               uns_d       = bus_if.req_unsigned;
               lo_d        = bus_if.req_addr[1:0];
               if (misaligned_c) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d     = ACCESS;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus_if.req_we;
                  mem_addr_d  = {bus_if.req_addr[31:2], 2'b00};
                  mem_be_d    = be_c;
                  mem_wdata_d = wdata_c;
`ifdef LSU_TIMEOUT_EN
                  cnt_d       = '0;
`endif
               end
            end
         end
         ACCESS: begin
            if (bus_if.mem_ack) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = mem_we_q ? 32'd0 : load_c;
            end else begin
               mem_req_d   = mem_req_q;
               mem_we_d    = mem_we_q;
               mem_addr_d  = mem_addr_q;
               mem_be_d    = mem_be_q;
               mem_wdata_d = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
               // Last waiting cycle: give up and report an error
               if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  mem_req_d   = 1'b0;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = 32'd0;
                  mem_be_d    = 4'd0;
                  mem_wdata_d = 32'd0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`endif
            end
         end
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_be_q    <= 4'd0;
         mem_wdata_q <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
         size_q      <= 2'd0;
         uns_q       <= 1'b0;
         lo_q        <= 2'd0;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lo_q        <= lo_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign bus_if.req_ready = req_ready_q;
   assign bus_if.mem_req   = mem_req_q;
   assign bus_if.mem_we    = mem_we_q;
   assign bus_if.mem_addr  = mem_addr_q;
   assign bus_if.mem_be    = mem_be_q;
   assign bus_if.mem_wdata = mem_wdata_q;
   assign bus_if.rsp_valid = rsp_valid_q;
   assign bus_if.rsp_rdata = rsp_rdata_q;
   assign bus_if.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table for single accesses, a response
// scoreboard, and hand sequences for stray ack, reset abort and timeout.
module tb_load_store_unit;
   logic clk;
   logic rst_n;
   load_store_unit_if bus ();

   load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_dly;
      logic        err;
      logic [31:0] exp_rdata;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t sb_q[$];
   int   checks;
   int   failures;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: every rsp_valid pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual=rsp_valid expected=none t=%0t", $time);
         end else begin
            rsp_t e;
            e = sb_q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(bus.req_ready), 32'd1);
   endtask

   task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      wait_ready();
      sb_q.push_back('{rdata: v.exp_rdata, err: v.err});
      drive_req(v.we, v.size, v.uns, v.addr, v.wdata);
      @(negedge clk);
      if (v.err) begin
         chk($sformatf("v%0d_err_no_mem_req", idx), 32'(bus.mem_req), 32'd0);
         chk($sformatf("v%0d_err_rsp_n1", idx), 32'(bus.rsp_valid), 32'd1);
      end else begin
         chk($sformatf("v%0d_mem_req", idx), 32'(bus.mem_req), 32'd1);
         chk($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.exp_addr);
         chk($sformatf("v%0d_mem_be", idx), 32'(bus.mem_be), 32'(v.exp_be));
         chk($sformatf("v%0d_mem_we", idx), 32'(bus.mem_we), 32'(v.we));
         if (v.we) chk($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, v.exp_wdata);
         repeat (v.ack_dly) @(negedge clk);
         chk($sformatf("v%0d_mem_req_held", idx), 32'(bus.mem_req), 32'd1);
         chk($sformatf("v%0d_mem_addr_held", idx), bus.mem_addr, v.exp_addr);
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = v.rdata;
         @(posedge clk);
         #1 bus.mem_ack = 1'b0;
         bus.mem_rdata = $urandom;
         @(negedge clk);
         chk($sformatf("v%0d_rsp_after_ack", idx), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("v%0d_mem_req_dropped", idx), 32'(bus.mem_req), 32'd0);
      end
      chk($sformatf("v%0d_no_ready_in_resp", idx), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_one_cycle", idx), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("v%0d_ready_after", idx), 32'(bus.req_ready), 32'd1);
   endtask

   vec_t vecs[14];

   initial begin
      checks   = 0;
      failures = 0;
      // we size uns addr wdata rdata dly err exp_rdata exp_addr be exp_wdata
      vecs[0]  = '{0, 2'b00, 0, 32'h0000_1003, 32'h0, 32'h80AB_CDEF, 1, 0, 32'hFFFF_FF80, 32'h0000_1000, 4'b1111, 32'h0};
      vecs[1]  = '{0, 2'b01, 1, 32'h0000_2002, 32'h0, 32'hFFFF_1234, 2, 0, 32'h0000_FFFF, 32'h0000_2000, 4'b1111, 32'h0};
      vecs[2]  = '{0, 2'b01, 0, 32'h0000_2002, 32'h0, 32'hFFFF_1234, 3, 0, 32'hFFFF_FFFF, 32'h0000_2000, 4'b1111, 32'h0};
      vecs[3]  = '{1, 2'b00, 0, 32'h0000_3001, 32'h0000_00A5, 32'h1111_1111, 1, 0, 32'h0, 32'h0000_3000, 4'b0010, 32'hA5A5_A5A5};
      vecs[4]  = '{1, 2'b10, 0, 32'h0000_4002, 32'h1234_5678, 32'h0, 0, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
      vecs[5]  = '{0, 2'b00, 1, 32'h0000_5001, 32'h0, 32'h1234_5678, 0, 0, 32'h0000_0056, 32'h0000_5000, 4'b1111, 32'h0};
      vecs[6]  = '{0, 2'b01, 0, 32'h0000_6000, 32'h0, 32'hABCD_8001, 1, 0, 32'hFFFF_8001, 32'h0000_6000, 4'b1111, 32'h0};
      vecs[7]  = '{1, 2'b01, 0, 32'h0000_7002, 32'hDEAD_BEEF, 32'h0, 4, 0, 32'h0, 32'h0000_7000, 4'b1100, 32'hBEEF_BEEF};
      vecs[8]  = '{1, 2'b10, 0, 32'h0000_8000, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h0000_8000, 4'b1111, 32'h1234_5678};
      vecs[9]  = '{0, 2'b10, 0, 32'h0000_9004, 32'h0, 32'hCAFE_F00D, 2, 0, 32'hCAFE_F00D, 32'h0000_9004, 4'b1111, 32'h0};
      vecs[10] = '{0, 2'b01, 0, 32'h0000_A001, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
      vecs[11] = '{0, 2'b11, 0, 32'h0000_B000, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
      vecs[12] = '{1, 2'b01, 0, 32'h0000_C000, 32'h0000_1234, 32'h0, 1, 0, 32'h0, 32'h0000_C000, 4'b0011, 32'h1234_1234};
      vecs[13] = '{0, 2'b00, 0, 32'h0000_D000, 32'h0, 32'h0000_007F, 1, 0, 32'h0000_007F, 32'h0000_D000, 4'b1111, 32'h0};

      rst_n            = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      bus.mem_ack      = 1'b0;
      bus.mem_rdata    = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

      // Stray mem_ack while idle must be ignored
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEAD_DEAD;
      @(posedge clk);
      #1 bus.mem_ack = 1'b0;
      @(negedge clk);
      chk("stray_ack_ready", 32'(bus.req_ready), 32'd1);
      chk("stray_ack_no_rsp", 32'(bus.rsp_valid), 32'd0);

      // Reset in ACCESS aborts the load with no response
      wait_ready();
      drive_req(1'b0, 2'b10, 1'b0, 32'h0000_E000, 32'h0);
      repeat (3) @(negedge clk);
      chk("abort_mem_req_before", 32'(bus.mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_mem_req_async", 32'(bus.mem_req), 32'd0);
      chk("abort_ready_async", 32'(bus.req_ready), 32'd1);
      chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_ready_after", 32'(bus.req_ready), 32'd1);

      // Request after reset still works
      run_vec(vecs[0], 100);

`ifdef LSU_TIMEOUT_EN
      begin
         int hi;
         int n;
         hi = 0;
         n  = 0;
         wait_ready();
         sb_q.push_back('{rdata: 32'h0, err: 1'b1});
         drive_req(1'b0, 2'b10, 1'b0, 32'h0000_F000, 32'h0);
         @(negedge clk);
         while (bus.mem_req === 1'b1 && n < 40) begin
            hi++;
            n++;
            @(negedge clk);
         end
         chk("timeout_mem_req_cycles", 32'(hi), 32'd16);
         chk("timeout_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         @(negedge clk);
         chk("timeout_ready_after", 32'(bus.req_ready), 32'd1);
      end
`endif

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
